// File: rtl/math_sched_pkg.sv
// math_sched_pkg: shared FSM state, AXI response codes and default widths
// for the math register-slave request scheduler.
package math_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RESP} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting at a registered pointer;
// the pointer moves past the winner whenever upd is high and a grant is made.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] ptr_q, ptr_d, k;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr_q) + i) % N);
      if (!found && req[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
    if (found) gnt[idx] = 1'b1;
    ptr_d = (upd && found) ? ((idx == W'(N - 1)) ? '0 : idx + W'(1)) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/math_axil_req_scheduler.sv
// math_axil_req_scheduler: shares one AXI4-Lite slave among NUM_REQ valid/ready requesters,
// one transaction at a time. Define TZ_WINDOW_FILTER_EN to reject non-secure access to the secure window.
module math_axil_req_scheduler
  import math_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] SECURE_BASE = ADDR_WIDTH'(8)
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt, sel_q, sel_d;
  logic [IW-1:0] idx;
  logic we_q, we_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0] prot_q, prot_d;
  logic [1:0] resp_q, resp_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(ACLK), .rst_n(ARESETN), .req(req_valid), .upd(state_q == S_IDLE), .gnt(gnt), .idx(idx)
  );
`ifndef TZ_WINDOW_FILTER_EN
  logic [ADDR_WIDTH-1:0] unused_secure_base;
  assign unused_secure_base = SECURE_BASE;
`endif
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    prot_d = prot_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    case (state_q)
      S_IDLE: if (|req_valid) begin
        sel_d = gnt;
        we_d = req_we[idx];
        addr_d = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
        prot_d = req_prot[idx*3 +: 3];
        rdata_d = '0;
        resp_d = RESP_OKAY;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        state_d = we_d ? S_WR : S_RD_A;
`ifdef TZ_WINDOW_FILTER_EN
        // non-secure access into the secure window is answered locally
        if (prot_d[1] && addr_d >= SECURE_BASE) begin
          resp_d = RESP_SLVERR;
          state_d = S_RESP;
        end
`endif
      end
      S_WR: begin
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: if (m_axi_bvalid) begin
        resp_d = m_axi_bresp;
        state_d = S_RESP;
      end
      S_RD_A: if (m_axi_arready) state_d = S_RD_R;
      S_RD_R: if (m_axi_rvalid) begin
        rdata_d = m_axi_rdata;
        resp_d = m_axi_rresp;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      prot_q <= '0;
      rdata_q <= '0;
      resp_q <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      prot_q <= prot_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  assign req_ready = (state_q == S_IDLE && ARESETN) ? gnt : '0;
  assign rsp_valid = (state_q == S_RESP) ? sel_q : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign m_axi_awaddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_axi_awprot = prot_q;
  assign m_axi_awvalid = (state_q == S_WR) && !aw_done_q;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = 4'hF;
  assign m_axi_wvalid = (state_q == S_WR) && !w_done_q;
  assign m_axi_bready = (state_q == S_WR_B);
  assign m_axi_araddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_axi_arprot = prot_q;
  assign m_axi_arvalid = (state_q == S_RD_A);
  assign m_axi_rready = (state_q == S_RD_R);
endmodule

// File: tb/tb_math_axil_req_scheduler.sv
// tb_math_axil_req_scheduler: randomized command streams against a round-robin /
// register-file reference model, with a stallable AXI4-Lite slave model.
module tb_math_axil_req_scheduler;
  localparam int N = 2;
  localparam int AW = 4;
  typedef struct {
    logic we;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [2:0] prot;
  } cmd_t;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [N-1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*3-1:0] req_prot = '0;
  logic [31:0] rsp_rdata, m_axi_wdata, m_axi_rdata;
  logic [1:0] rsp_resp, m_axi_bresp, m_axi_rresp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  always #5 ACLK = ~ACLK;
  math_axil_req_scheduler dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );
  // AXI4-Lite slave model: four registers, programmable handshake delays
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] smem [4] = '{default: 32'h0};
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, cyc = 0, b_cyc = 0, r_cyc = 0;
  logic got_aw = 0, got_w = 0, bpend = 0, rpend = 0;
  logic [31:0] rdata_l = '0, last_wdata = '0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [2:0] last_awprot = '0;
  logic [3:0] last_wstrb = '0;
  logic aw_hs, w_hs, ar_hs;
  logic [AW-1:0] wa;
  logic [31:0] wd;
  assign m_axi_awready = m_axi_awvalid && aw_wait >= aw_delay;
  assign m_axi_wready = m_axi_wvalid && w_wait >= w_delay;
  assign m_axi_arready = m_axi_arvalid && ar_wait >= ar_delay;
  assign m_axi_bvalid = bpend && b_cnt >= b_delay;
  assign m_axi_rvalid = rpend && r_cnt >= r_delay;
  assign m_axi_bresp = bresp_val;
  assign m_axi_rresp = rresp_val;
  assign m_axi_rdata = rdata_l;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign wa = aw_hs ? m_axi_awaddr : last_awaddr;
  assign wd = w_hs ? m_axi_wdata : last_wdata;
  always @(posedge ACLK) cyc <= cyc + 1;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 0; got_w <= 0; bpend <= 0; rpend <= 0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin got_aw <= 1; last_awaddr <= m_axi_awaddr; last_awprot <= m_axi_awprot; n_aw <= n_aw + 1; end
      if (w_hs) begin got_w <= 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb; n_w <= n_w + 1; end
      if ((got_aw || aw_hs) && (got_w || w_hs) && !bpend) begin
        bpend <= 1; b_cnt <= 0; smem[wa[3:2]] <= wd;
      end else if (bpend) b_cnt <= b_cnt + 1;
      if (m_axi_bvalid && m_axi_bready) begin bpend <= 0; got_aw <= 0; got_w <= 0; b_cyc <= cyc; end
      if (ar_hs) begin rpend <= 1; r_cnt <= 0; rdata_l <= smem[m_axi_araddr[3:2]]; last_araddr <= m_axi_araddr; n_ar <= n_ar + 1; end
      else if (rpend) r_cnt <= r_cnt + 1;
      if (m_axi_rvalid && m_axi_rready) begin rpend <= 0; r_cyc <= cyc; end
    end
  end
  // stimulus, reference model and observations
  cmd_t cmds [N][16];
  int ncmd [N];
  int checks = 0, failures = 0;
  int model_ptr = 0;
  logic [31:0] model_mem [4] = '{default: 32'h0};
  int exp_r[$], obs_r[$], obs_lat[$], obs_cyc[$], gnt_q[$];
  logic [31:0] exp_d[$], obs_d[$];
  logic [1:0] exp_s[$], obs_s[$];
  int multi_rdy, bad_rsp;
  task automatic clear_cmds();
    for (int r = 0; r < N; r++) ncmd[r] = 0;
  endtask
  task automatic add_cmd(int r, logic we, logic [AW-1:0] addr, logic [31:0] data, logic [2:0] prot);
    cmds[r][ncmd[r]] = '{we, addr, data, prot};
    ncmd[r]++;
  endtask
  // every requester keeps its next command pending, so grants simply rotate over non-empty queues
  task automatic model_run();
    int nxt [N];
    int total, c;
    cmd_t m;
    logic deny;
    exp_r.delete(); exp_d.delete(); exp_s.delete();
    total = 0;
    for (int r = 0; r < N; r++) begin nxt[r] = 0; total += ncmd[r]; end
    for (int n = 0; n < total; n++) begin
      c = -1;
      for (int k = 0; k < N; k++)
        if (c < 0 && nxt[(model_ptr + k) % N] < ncmd[(model_ptr + k) % N]) c = (model_ptr + k) % N;
      m = cmds[c][nxt[c]];
      nxt[c]++;
`ifdef TZ_WINDOW_FILTER_EN
      deny = m.prot[1] && m.addr >= 4'h8;
`else
      deny = 1'b0;
`endif
      exp_r.push_back(c);
      if (deny) begin exp_d.push_back(0); exp_s.push_back(2'b10); end
      else if (m.we) begin model_mem[m.addr[3:2]] = m.data; exp_d.push_back(0); exp_s.push_back(bresp_val); end
      else begin exp_d.push_back(model_mem[m.addr[3:2]]); exp_s.push_back(rresp_val); end
      model_ptr = (c + 1) % N;
    end
  endtask
  task automatic run_engine();
    int nxt [N];
    int total, done, gt;
    total = 0; done = 0; gt = 0; multi_rdy = 0; bad_rsp = 0;
    for (int r = 0; r < N; r++) begin nxt[r] = 0; total += ncmd[r]; end
    obs_r.delete(); obs_d.delete(); obs_s.delete(); obs_lat.delete(); obs_cyc.delete(); gnt_q.delete();
    @(negedge ACLK);
    for (int t = 0; t < 3000 && done < total; t++) begin
      for (int r = 0; r < N; r++) begin
        req_valid[r] = nxt[r] < ncmd[r];
        if (nxt[r] < ncmd[r]) begin
          req_we[r] = cmds[r][nxt[r]].we;
          req_addr[r*AW +: AW] = cmds[r][nxt[r]].addr;
          req_wdata[r*32 +: 32] = cmds[r][nxt[r]].data;
          req_prot[r*3 +: 3] = cmds[r][nxt[r]].prot;
        end
      end
      #1;
      if ($countones(req_ready) > 1) multi_rdy++;
      for (int r = 0; r < N; r++) if (req_ready[r]) begin gnt_q.push_back(r); gt = t; nxt[r]++; end
      if (rsp_valid != '0) begin
        if ($countones(rsp_valid) != 1) bad_rsp++;
        for (int r = 0; r < N; r++) if (rsp_valid[r]) obs_r.push_back(r);
        obs_d.push_back(rsp_rdata); obs_s.push_back(rsp_resp);
        obs_lat.push_back(t - gt + 1); obs_cyc.push_back(cyc);
        done++;
      end
      @(negedge ACLK);
    end
    req_valid = '0;
  endtask
  task automatic test_reset();
    req_valid = '1;
    @(negedge ACLK); #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0) begin
      failures++; $display("FAIL reset_ready_rsp got ready=%b rsp=%b exp 0", req_ready, rsp_valid);
    end
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
      failures++; $display("FAIL reset_axi_valids got=%b exp=00000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_data got=%h/%b exp 0/00", rsp_rdata, rsp_resp);
    end
    req_valid = '0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_ptr = 0;
    @(negedge ACLK); #1;
    checks++;
    if (rsp_valid !== '0 || m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got rsp=%b aw=%b ar=%b exp 0", rsp_valid, m_axi_awvalid, m_axi_arvalid);
    end
  endtask
  task automatic test_write_read();
    int aw0, w0, ar0;
    aw0 = n_aw; w0 = n_w; ar0 = n_ar;
    clear_cmds();
    add_cmd(0, 1'b1, 4'h4, 32'h0000_0002, 3'b000);
    add_cmd(0, 1'b0, 4'h4, 32'h0, 3'b000);
    model_run();
    run_engine();
    checks++;
    if (obs_r.size() != 2) begin failures++; $display("FAIL wr_rd_count got=%0d exp=2", obs_r.size()); end
    for (int i = 0; i < obs_r.size() && i < 2; i++) begin
      checks++;
      if (obs_r[i] != exp_r[i] || obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
        failures++; $display("FAIL wr_rd_rsp%0d got r=%0d d=%h s=%b exp r=%0d d=%h s=%b",
          i, obs_r[i], obs_d[i], obs_s[i], exp_r[i], exp_d[i], exp_s[i]);
      end
      checks++;
      if (obs_lat[i] != 4) begin failures++; $display("FAIL wr_rd_latency%0d got=%0d exp=4", i, obs_lat[i]); end
    end
    checks++;
    if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_ar - ar0 != 1) begin
      failures++; $display("FAIL wr_rd_handshakes got aw=%0d w=%0d ar=%0d exp 1/1/1", n_aw - aw0, n_w - w0, n_ar - ar0);
    end
  endtask
  task automatic test_contention();
    for (int rep = 0; rep < 3; rep++) begin
      clear_cmds();
      bresp_val = 2'($urandom); rresp_val = 2'($urandom);
      for (int r = 0; r < N; r++)
        for (int i = 0; i < 4; i++)
          add_cmd(r, 1'($urandom), 4'($urandom), $urandom, 3'($urandom));
      model_run();
      run_engine();
      checks++;
      if (gnt_q.size() != 8 || obs_r.size() != 8) begin
        failures++; $display("FAIL cont_count rep%0d got grants=%0d rsps=%0d exp 8/8", rep, gnt_q.size(), obs_r.size());
      end
      for (int i = 0; i < 8 && i < obs_r.size() && i < gnt_q.size(); i++) begin
        checks++;
        if (gnt_q[i] != exp_r[i] || obs_r[i] != exp_r[i] || obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
          failures++; $display("FAIL cont_rsp rep%0d #%0d got g=%0d r=%0d d=%h s=%b exp r=%0d d=%h s=%b",
            rep, i, gnt_q[i], obs_r[i], obs_d[i], obs_s[i], exp_r[i], exp_d[i], exp_s[i]);
        end
      end
      checks++;
      if (multi_rdy != 0 || bad_rsp != 0) begin
        failures++; $display("FAIL cont_onehot rep%0d got multi_ready=%0d bad_rsp=%0d exp 0/0", rep, multi_rdy, bad_rsp);
      end
    end
    bresp_val = 2'b00; rresp_val = 2'b00;
  endtask
  task automatic test_stalls();
    int aw0, w0;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 3 : 0; w_delay = (k == 0) ? 0 : 3; b_delay = 5;
      aw0 = n_aw; w0 = n_w;
      a = 4'($urandom);
      clear_cmds();
      add_cmd(1, 1'b1, a, $urandom, 3'b000);
      add_cmd(1, 1'b0, a, 32'h0, 3'b000);
      ar_delay = 2; r_delay = 3;
      model_run();
      run_engine();
      checks++;
      if (n_aw - aw0 != 1 || n_w - w0 != 1) begin
        failures++; $display("FAIL stall%0d_handshakes got aw=%0d w=%0d exp 1/1", k, n_aw - aw0, n_w - w0);
      end
      checks++;
      if (obs_cyc.size() != 2 || obs_cyc[0] != b_cyc + 1 || obs_cyc[1] != r_cyc + 1) begin
        failures++; $display("FAIL stall%0d_rsp_timing got n=%0d exp rsp one cycle after B (%0d) and R (%0d)",
          k, obs_cyc.size(), b_cyc, r_cyc);
      end
      checks++;
      if (obs_d.size() != 2 || obs_d[1] !== exp_d[1] || obs_s[0] !== exp_s[0]) begin
        failures++; $display("FAIL stall%0d_data got n=%0d exp rdata=%h", k, obs_d.size(), exp_d[1]);
      end
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
  endtask
  task automatic test_sweep();
    logic [31:0] u;
    u = $urandom;
    clear_cmds();
    for (int i = 0; i < 4; i++) add_cmd(0, 1'b1, 4'(i * 4), 32'(i + 1), 3'b000);
    for (int i = 0; i < 4; i++) add_cmd(0, 1'b0, 4'(i * 4), 32'h0, 3'b000);
    add_cmd(0, 1'b1, 4'h5, u, 3'b001);
    add_cmd(0, 1'b0, 4'h7, 32'h0, 3'b001);
    model_run();
    run_engine();
    checks++;
    if (obs_r.size() != 10) begin failures++; $display("FAIL sweep_count got=%0d exp=10", obs_r.size()); end
    for (int i = 0; i < 10 && i < obs_r.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i] || obs_lat[i] != 4) begin
        failures++; $display("FAIL sweep_rsp%0d got d=%h s=%b lat=%0d exp d=%h s=%b lat=4",
          i, obs_d[i], obs_s[i], obs_lat[i], exp_d[i], exp_s[i]);
      end
    end
    checks++;
    if (last_awaddr !== 4'h4 || last_araddr !== 4'h4) begin
      failures++; $display("FAIL unaligned_addr got aw=%h ar=%h exp 4/4", last_awaddr, last_araddr);
    end
    checks++;
    if (last_wstrb !== 4'hF || last_awprot !== 3'b001) begin
      failures++; $display("FAIL wstrb_prot got strb=%h prot=%b exp F/001", last_wstrb, last_awprot);
    end
  endtask
  task automatic test_reset_mid();
    logic seen;
    logic [31:0] d;
    int stray;
    d = $urandom; seen = 0; stray = 0;
    b_delay = 40;
    @(negedge ACLK);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[AW +: AW] = 4'hC; req_wdata[32 +: 32] = d; req_prot[3 +: 3] = 3'b000;
    @(negedge ACLK);
    req_valid = '0;
    for (int t = 0; t < 20 && !seen; t++) begin
      #1;
      if (m_axi_bready) seen = 1;
      else @(negedge ACLK);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL reach_wr_b got bready=0 exp 1 within 20 cycles"); end
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0 || rsp_valid !== '0) begin
      failures++; $display("FAIL reset_mid_valids got axi=%b rsp=%b exp 0",
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, rsp_valid);
    end
    model_mem[3] = d;
    model_ptr = 0;
    b_delay = 0;
    @(negedge ACLK); @(negedge ACLK);
    ARESETN = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge ACLK); #1;
      if (rsp_valid !== '0) stray++;
    end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL reset_mid_no_rsp got %0d stray responses exp 0", stray); end
    clear_cmds();
    add_cmd(1, 1'b0, 4'h0, 32'h0, 3'b000);
    add_cmd(0, 1'b0, 4'hC, 32'h0, 3'b000);
    model_run();
    run_engine();
    checks++;
    if (gnt_q.size() != 2 || gnt_q[0] != 0 || obs_r.size() != 2) begin
      failures++; $display("FAIL post_reset_ptr got grants=%0d first=%0d exp 2 grants first=0",
        gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1);
    end
    checks++;
    if (obs_d.size() != 2 || obs_d[0] !== exp_d[0] || obs_d[1] !== exp_d[1]) begin
      failures++; $display("FAIL post_reset_data got n=%0d exp d0=%h d1=%h", obs_d.size(), exp_d[0], exp_d[1]);
    end
  endtask
  task automatic test_tz();
    int aw0;
    int exp_lat, exp_aw;
`ifdef TZ_WINDOW_FILTER_EN
    exp_lat = 2; exp_aw = 1;
`else
    exp_lat = 4; exp_aw = 2;
`endif
    aw0 = n_aw;
    clear_cmds();
    add_cmd(1, 1'b1, 4'h8, $urandom, 3'b010);
    add_cmd(1, 1'b1, 4'h8, $urandom, 3'b000);
    model_run();
    run_engine();
    checks++;
    if (obs_r.size() != 2) begin failures++; $display("FAIL tz_count got=%0d exp=2", obs_r.size()); end
    for (int i = 0; i < 2 && i < obs_r.size(); i++) begin
      checks++;
      if (obs_r[i] != 1 || obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
        failures++; $display("FAIL tz_rsp%0d got r=%0d d=%h s=%b exp r=1 d=%h s=%b", i, obs_r[i], obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
      end
    end
    checks++;
    if (obs_lat.size() != 2 || obs_lat[0] != exp_lat || obs_lat[1] != 4) begin
      failures++; $display("FAIL tz_latency got n=%0d first=%0d exp first=%0d second=4",
        obs_lat.size(), (obs_lat.size() > 0) ? obs_lat[0] : -1, exp_lat);
    end
    checks++;
    if (n_aw - aw0 != exp_aw) begin failures++; $display("FAIL tz_aw_count got=%0d exp=%0d", n_aw - aw0, exp_aw); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_stalls();
    test_sweep();
    test_reset_mid();
    test_tz();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/math_axil_req_scheduler.md
Name: math_axil_req_scheduler

Overview:
Shares the math AXI4-Lite register slave (four 32-bit registers, offsets 0x0-0xC) between NUM_REQ on-chip requesters, e.g. secure and non-secure reconfiguration managers. Each requester uses a simple valid/ready command port. The block grants one command at a time with round-robin priority, runs it as a single AXI4-Lite write or read on its master port, and returns the response to the granted requester only. It sits between the requesters and the math slave's S00_AXI port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, AXI byte-address width
DATA_WIDTH, 32, AXI data width (fixed 32)
SECURE_BASE, 4'h8, first byte address of the secure register window (used only with the optional feature)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  command valid, one bit per requester
req_ready  out  NUM_REQ  command accepted, one-hot pulse
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  byte address, packed
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, packed
req_prot  in  NUM_REQ*3  AXI prot; bit1 = non-secure
rsp_valid  out  NUM_REQ  response pulse, one-hot to the granted requester
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_resp  out  2  AXI response code, valid with rsp_valid
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AR channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel

Behaviour:
- Reset (async assert, sync release): state IDLE; all req_ready, rsp_valid and m_axi_*valid/ready outputs 0; rsp_rdata 0; rsp_resp 0; rr_ptr 0. Reset asserted mid-transaction abandons it without emitting a response. The slave shares ARESETN.
- States: IDLE, WR (AW+W), WR_B, RD_A, RD_R, RESP.
- IDLE: when any req_valid is set, grant the first set bit at or after rr_ptr, with wrap. In the same cycle, pulse req_ready for the granted requester and latch its we, addr, wdata and prot. Then rr_ptr = grant+1 mod NUM_REQ. Next state is WR or RD_A.
- WR: awvalid and wvalid both assert in the cycle after the grant. Each channel drops independently on its own handshake; AW and W may complete in either order or together. When both are done, go to WR_B.
- WR_B: bready=1. On bvalid, latch bresp and go to RESP.
- RD_A: arvalid=1 until arready. Then go to RD_R.
- RD_R: rready=1. On rvalid, latch rdata and rresp and go to RESP.
- RESP: rsp_valid pulses for exactly 1 cycle to the granted requester. rsp_rdata is 0 for writes. Return to IDLE. A new grant can occur in the IDLE cycle that follows.
- AXI address fields: awaddr/araddr equal the latched address with bits[1:0] forced to 0. wstrb is 4'hF. awprot/arprot carry the latched prot.
- Minimum latency, request to rsp_valid, with zero-wait slave: write 4 cycles, read 4 cycles.
- Only one outstanding transaction at a time. req_valid on non-granted ports is held and not acknowledged.
- Requester rules: a requester holds its command stable until req_ready. Deasserting req_valid before req_ready is legal; the command is simply not granted.
- Unknown AXI resp values are forwarded unchanged.

Optional Feature:
TZ_WINDOW_FILTER_EN
- Defined: a command with prot[1]=1 and addr >= SECURE_BASE is granted normally (req_ready pulses) but issues no AXI transaction. FSM goes directly to RESP with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0. Latency is 2 cycles.
- Undefined: prot is passed through unchecked and SECURE_BASE is unused.

Decomposition:
- Package math_sched_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), default widths.
- Sub-module rr_arbiter: combinational one-hot grant from a request vector and a pointer, with the registered pointer update. Reused elsewhere in the design.

Test Plan:
- Single write then read, req0: write addr 0x4, data 0x00000002, then read addr 0x4 -> one AW/W, one AR; rsp_resp=00 and rsp_rdata=0x00000002, 4 cycles each with zero-wait slave.
- Contention: req0 and req1 held continuously, 4 commands each -> grants alternate 0,1,0,1...; req_ready is never set on two bits at once.
- Stalls: slave holds awready 3 cycles and wready 0 cycles, then the reverse; bvalid delayed 5 cycles -> exactly one AW and one W handshake; rsp_valid comes 1 cycle after B.
- Sequential sweep: write 1,2,3,4 to 0x0-0xC, read them back -> data matches; unaligned addr 0x5 drives awaddr 0x4.
- Reset in WR_B: assert ARESETN low -> all valids drop immediately and no rsp_valid is emitted; after release, a new request is serviced from rr_ptr 0.
- With TZ_WINDOW_FILTER_EN: req1 with prot 3'b010 writes 0x8 -> no AW; rsp_resp=10 after 2 cycles. The same write with prot 3'b000 -> OKAY.
